// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the three-port SDRAM arbiter.
package ram_arbiter_pkg;

  localparam int ADDR_W = 25;
  localparam int DATA_W = 128;

  // Tag stored per outstanding read: which reader the returned data belongs to
  localparam logic TAG_VGA = 1'b0;
  localparam logic TAG_HDR = 1'b1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    PORT_NONE = 2'd0,
    PORT_VGA  = 2'd1,
    PORT_CAM  = 2'd2,
    PORT_HDR  = 2'd3
  } port_t;

endpackage

// File: rtl/ram_tag_fifo.sv
// In-order read-tag FIFO: records which reader owns each outstanding SDRAM read.
module ram_tag_fifo #(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_push,
  input  logic i_din,
  input  logic i_pop,
  output logic o_dout,
  output logic o_full,
  output logic o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0] r_mem;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_dout  = r_mem[r_rd_ptr];

  // NOTE: storage has no reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one SDRAM controller port between camera writer, VGA reader and HDR reader,
// with fixed priority, HDR anti-starvation and in-order read-data return.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int TAG_DEPTH    = 8,
  parameter int STARVE_LIMIT = 16
) (
  input  logic              clk_133M,
  input  logic              rst_133M,
  input  logic              cam_wr_req,
  input  logic [ADDR_W-1:0] cam_wr_address,
  input  logic [DATA_W-1:0] cam_data,
  output logic              cam_busy,
  input  logic              vga_rd_req,
  input  logic [ADDR_W-1:0] vga_rd_address,
  output logic              vga_busy,
  output logic [DATA_W-1:0] vga_rd_data,
  output logic              vga_rd_valid,
  input  logic              hdr_rd_req,
  input  logic [ADDR_W-1:0] hdr_rd_address,
  output logic              hdr_busy,
  output logic [DATA_W-1:0] hdr_rd_data,
  output logic              hdr_rd_valid,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic              ram_busy,
  input  logic [DATA_W-1:0] ram_rd_data,
  input  logic              ram_rd_valid,
  output logic              tag_err
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  state_t            r_state, w_next_state;
  port_t             r_winner, w_winner;
  logic              r_cam_full, r_vga_full, r_hdr_full;
  logic [ADDR_W-1:0] r_cam_addr, r_vga_addr, r_hdr_addr;
  logic [DATA_W-1:0] r_cam_data;
  logic [CNT_W-1:0]  r_starve_cnt;
  logic              r_ram_we;
  logic [ADDR_W-1:0] r_ram_address;
  logic [DATA_W-1:0] r_ram_wdata;
  logic [DATA_W-1:0] r_vga_rd_data, r_hdr_rd_data;
  logic              r_vga_rd_valid, r_hdr_rd_valid, r_tag_err;
  logic              w_fifo_full, w_fifo_empty, w_fifo_dout;
  logic              w_vga_elig, w_hdr_elig, w_force_hdr, w_go, w_issue, w_push;

  // Reads may only be issued while a tag slot is free for their return.
  assign w_vga_elig  = r_vga_full & ~w_fifo_full;
  assign w_hdr_elig  = r_hdr_full & ~w_fifo_full;
  assign w_force_hdr = (r_starve_cnt >= CNT_W'(STARVE_LIMIT)) & w_hdr_elig;
  assign w_go        = (r_state == ST_IDLE) & ~ram_busy & (w_winner != PORT_NONE);
  assign w_issue     = (r_state == ST_GRANT);
  assign w_push      = w_go & ((w_winner == PORT_VGA) | (w_winner == PORT_HDR));

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_winner = PORT_NONE;
    if (w_force_hdr)     w_winner = PORT_HDR;
    else if (w_vga_elig) w_winner = PORT_VGA;
    else if (r_cam_full) w_winner = PORT_CAM;
    else if (w_hdr_elig) w_winner = PORT_HDR;
  end

  always_ff @(posedge clk_133M or posedge rst_133M) begin
    if (rst_133M) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_go) w_next_state = ST_GRANT;
      ST_GRANT: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    ram_req = (r_state == ST_GRANT);
  end

  // Request slots: capture only when empty, release on the issue cycle.
  always_ff @(posedge clk_133M or posedge rst_133M) begin
    if (rst_133M) begin
      r_cam_full <= 1'b0;
      r_vga_full <= 1'b0;
      r_hdr_full <= 1'b0;
      r_cam_addr <= '0;
      r_vga_addr <= '0;
      r_hdr_addr <= '0;
      r_cam_data <= '0;
    end else begin
      if (w_issue && r_winner == PORT_CAM) r_cam_full <= 1'b0;
      else if (!r_cam_full && cam_wr_req) begin
        r_cam_full <= 1'b1;
        r_cam_addr <= cam_wr_address;
        r_cam_data <= cam_data;
      end
      if (w_issue && r_winner == PORT_VGA) r_vga_full <= 1'b0;
      else if (!r_vga_full && vga_rd_req) begin
        r_vga_full <= 1'b1;
        r_vga_addr <= vga_rd_address;
      end
      if (w_issue && r_winner == PORT_HDR) r_hdr_full <= 1'b0;
      else if (!r_hdr_full && hdr_rd_req) begin
        r_hdr_full <= 1'b1;
        r_hdr_addr <= hdr_rd_address;
      end
    end
  end

  always_ff @(posedge clk_133M or posedge rst_133M) begin
    if (rst_133M) begin
      r_winner      <= PORT_NONE;
      r_ram_we      <= 1'b0;
      r_ram_address <= '0;
      r_ram_wdata   <= '0;
      r_starve_cnt  <= '0;
    end else begin
      if (w_go) begin
        r_winner    <= w_winner;
        r_ram_we    <= (w_winner == PORT_CAM);
        r_ram_wdata <= (w_winner == PORT_CAM) ? r_cam_data : '0;
        case (w_winner)
          PORT_VGA: r_ram_address <= r_vga_addr;
          PORT_CAM: r_ram_address <= r_cam_addr;
          PORT_HDR: r_ram_address <= r_hdr_addr;
          default:  r_ram_address <= r_ram_address;
        endcase
      end
      // Counts grants HDR loses while waiting; saturates at the force threshold.
      if (!r_hdr_full) r_starve_cnt <= '0;
      else if (w_go) begin
        if (w_winner == PORT_HDR) r_starve_cnt <= '0;
        else if (r_starve_cnt != CNT_W'(STARVE_LIMIT)) r_starve_cnt <= r_starve_cnt + CNT_W'(1);
      end
    end
  end

  ram_tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk     (clk_133M),
    .rst     (rst_133M),
    .i_push  (w_push),
    .i_din   ((w_winner == PORT_HDR) ? TAG_HDR : TAG_VGA),
    .i_pop   (ram_rd_valid),
    .o_dout  (w_fifo_dout),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Read-return demux: data goes to whichever reader owns the oldest tag.
  always_ff @(posedge clk_133M or posedge rst_133M) begin
    if (rst_133M) begin
      r_vga_rd_data  <= '0;
      r_hdr_rd_data  <= '0;
      r_vga_rd_valid <= 1'b0;
      r_hdr_rd_valid <= 1'b0;
      r_tag_err      <= 1'b0;
    end else begin
      r_vga_rd_valid <= 1'b0;
      r_hdr_rd_valid <= 1'b0;
      if (ram_rd_valid) begin
        if (w_fifo_empty) r_tag_err <= 1'b1;
        else if (w_fifo_dout == TAG_VGA) begin
          r_vga_rd_data  <= ram_rd_data;
          r_vga_rd_valid <= 1'b1;
        end else begin
          r_hdr_rd_data  <= ram_rd_data;
          r_hdr_rd_valid <= 1'b1;
        end
      end
    end
  end

  assign cam_busy     = r_cam_full;
  assign vga_busy     = r_vga_full;
  assign hdr_busy     = r_hdr_full;
  assign ram_we       = r_ram_we;
  assign ram_address  = r_ram_address;
  assign ram_wdata    = r_ram_wdata;
  assign vga_rd_data  = r_vga_rd_data;
  assign vga_rd_valid = r_vga_rd_valid;
  assign hdr_rd_data  = r_hdr_rd_data;
  assign hdr_rd_valid = r_hdr_rd_valid;
  assign tag_err      = r_tag_err;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter: latency, priority, tag return,
// tag-FIFO back-pressure, HDR anti-starvation, ram_busy stall and async reset.
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  logic              clk_133M = 1'b0;
  logic              rst_133M = 1'b1;
  logic              cam_wr_req = 1'b0;
  logic [ADDR_W-1:0] cam_wr_address = '0;
  logic [DATA_W-1:0] cam_data = '0;
  logic              cam_busy;
  logic              vga_rd_req = 1'b0;
  logic [ADDR_W-1:0] vga_rd_address = '0;
  logic              vga_busy;
  logic [DATA_W-1:0] vga_rd_data;
  logic              vga_rd_valid;
  logic              hdr_rd_req = 1'b0;
  logic [ADDR_W-1:0] hdr_rd_address = '0;
  logic              hdr_busy;
  logic [DATA_W-1:0] hdr_rd_data;
  logic              hdr_rd_valid;
  logic              ram_req;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_busy = 1'b0;
  logic [DATA_W-1:0] ram_rd_data = '0;
  logic              ram_rd_valid = 1'b0;
  logic              tag_err;

  int n_checks = 0;
  int n_errors = 0;

  ram_arbiter #(
    .TAG_DEPTH    (8),
    .STARVE_LIMIT (16)
  ) dut (
    .clk_133M       (clk_133M),
    .rst_133M       (rst_133M),
    .cam_wr_req     (cam_wr_req),
    .cam_wr_address (cam_wr_address),
    .cam_data       (cam_data),
    .cam_busy       (cam_busy),
    .vga_rd_req     (vga_rd_req),
    .vga_rd_address (vga_rd_address),
    .vga_busy       (vga_busy),
    .vga_rd_data    (vga_rd_data),
    .vga_rd_valid   (vga_rd_valid),
    .hdr_rd_req     (hdr_rd_req),
    .hdr_rd_address (hdr_rd_address),
    .hdr_busy       (hdr_busy),
    .hdr_rd_data    (hdr_rd_data),
    .hdr_rd_valid   (hdr_rd_valid),
    .ram_req        (ram_req),
    .ram_we         (ram_we),
    .ram_address    (ram_address),
    .ram_wdata      (ram_wdata),
    .ram_busy       (ram_busy),
    .ram_rd_data    (ram_rd_data),
    .ram_rd_valid   (ram_rd_valid),
    .tag_err        (tag_err)
  );

  always #5 clk_133M = ~clk_133M;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_133M);
    #1;
  endtask

  task automatic wait_req(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      tick();
      if (ram_req) seen = 1'b1;
    end
  endtask

  initial begin
    bit seen;
    bit saw;
    bit hdr_ret;
    int grants;
    int hdr_at;

    // Reset state
    tick();
    tick();
    check("rst_ram_req", ram_req, 1'b0);
    check("rst_busy", {cam_busy, vga_busy, hdr_busy}, 3'b000);
    check("rst_valid_err", {vga_rd_valid, hdr_rd_valid, tag_err}, 3'b000);
    rst_133M = 1'b0;
    tick();

    // 1. Single camera write: busy at N+1, ram_req at N+2
    cam_wr_req = 1'b1;
    cam_wr_address = 25'h25800;
    cam_data = {16{8'hA5}};
    tick();
    cam_wr_req = 1'b0;
    check("t1_busy_n1", cam_busy, 1'b1);
    check("t1_noreq_n1", ram_req, 1'b0);
    tick();
    check("t1_req_n2", {ram_req, ram_we}, 2'b11);
    check("t1_addr", ram_address, 25'h25800);
    check("t1_wdata", ram_wdata, {16{8'hA5}});
    check("t1_busy_n2", cam_busy, 1'b1);
    tick();
    check("t1_idle_n3", {ram_req, cam_busy}, 2'b00);

    // 2. Simultaneous requests: VGA at N+2, CAM at N+4, HDR at N+6
    vga_rd_req = 1'b1;  vga_rd_address = 25'h100;
    cam_wr_req = 1'b1;  cam_wr_address = 25'h300;  cam_data = {16{8'h3C}};
    hdr_rd_req = 1'b1;  hdr_rd_address = 25'h200;
    tick();
    vga_rd_req = 1'b0;  cam_wr_req = 1'b0;  hdr_rd_req = 1'b0;
    tick();
    check("t2_vga_n2", {ram_req, ram_we, ram_address}, {2'b10, 25'h100});
    tick();
    check("t2_gap_n3", ram_req, 1'b0);
    tick();
    check("t2_cam_n4", {ram_req, ram_we, ram_address}, {2'b11, 25'h300});
    tick();
    tick();
    check("t2_hdr_n6", {ram_req, ram_we, ram_address}, {2'b10, 25'h200});
    tick();

    // 3. Returns in issue order: VGA gets 0x11.., HDR gets 0x22..
    ram_rd_valid = 1'b1;
    ram_rd_data = {16{8'h11}};
    tick();
    ram_rd_data = {16{8'h22}};
    check("t3_vga_valid", {vga_rd_valid, hdr_rd_valid}, 2'b10);
    check("t3_vga_data", vga_rd_data, {16{8'h11}});
    tick();
    ram_rd_valid = 1'b0;
    check("t3_hdr_valid", {vga_rd_valid, hdr_rd_valid}, 2'b01);
    check("t3_hdr_data", hdr_rd_data, {16{8'h22}});
    check("t3_vga_held", vga_rd_data, {16{8'h11}});
    check("t3_no_err", tag_err, 1'b0);
    tick();

    // 4. Eight outstanding VGA reads fill the tag FIFO
    for (int i = 0; i < 8; i++) begin
      vga_rd_req = 1'b1;
      vga_rd_address = 25'h1000 + 25'(i);
      tick();
      vga_rd_req = 1'b0;
      wait_req(8, seen);
      check($sformatf("t4_read%0d", i), {seen, ram_address}, {1'b1, 25'h1000 + 25'(i)});
      tick();
    end
    vga_rd_req = 1'b1;
    vga_rd_address = 25'h1008;
    tick();
    vga_rd_req = 1'b0;
    saw = 1'b0;
    repeat (10) begin
      tick();
      if (ram_req) saw = 1'b1;
    end
    check("t4_ninth_held", saw, 1'b0);
    check("t4_vga_busy", vga_busy, 1'b1);
    cam_wr_req = 1'b1;
    cam_wr_address = 25'h4000;
    cam_data = {16{8'h5A}};
    tick();
    cam_wr_req = 1'b0;
    wait_req(8, seen);
    check("t4_cam_granted", {seen, ram_we, ram_address}, {2'b11, 25'h4000});
    tick();
    ram_rd_valid = 1'b1;
    ram_rd_data = {4{32'hDEADBEEF}};
    tick();
    ram_rd_valid = 1'b0;
    check("t4_pop_valid", {vga_rd_valid, vga_rd_data}, {1'b1, {4{32'hDEADBEEF}}});
    wait_req(8, seen);
    check("t4_ninth_granted", {seen, ram_we, ram_address}, {2'b10, 25'h1008});
    tick();
    ram_rd_valid = 1'b1;
    repeat (8) tick();
    ram_rd_valid = 1'b0;
    tick();
    check("t4_drain_no_err", {tag_err, vga_busy}, 2'b00);

    // 5. HDR starved by continuous VGA/CAM traffic is forced on grant 17
    hdr_rd_req = 1'b1;  hdr_rd_address = 25'h5000;
    vga_rd_req = 1'b1;  vga_rd_address = 25'h6000;
    cam_wr_req = 1'b1;  cam_wr_address = 25'h7000;  cam_data = {16{8'h77}};
    tick();
    hdr_rd_req = 1'b0;
    grants = 0;
    hdr_at = 0;
    hdr_ret = 1'b0;
    for (int c = 0; c < 90; c++) begin
      tick();
      ram_rd_valid = 1'b0;
      if (hdr_rd_valid) hdr_ret = 1'b1;
      if (ram_req) begin
        grants++;
        if (!ram_we) begin
          ram_rd_valid = 1'b1;
          ram_rd_data = {4{32'h0000_0000 + 32'(grants)}};
        end
        if (ram_address == 25'h5000 && !ram_we && hdr_at == 0) begin
          hdr_at = grants;
          vga_rd_req = 1'b0;
          cam_wr_req = 1'b0;
        end
      end
    end
    ram_rd_valid = 1'b0;
    check("t5_hdr_grant_index", hdr_at, 17);
    check("t5_hdr_returned", hdr_ret, 1'b1);
    check("t5_idle_after", {cam_busy, vga_busy, hdr_busy, tag_err}, 4'b0000);
    tick();

    // 6. ram_busy stalls everything; async reset mid-grant; stray return flags tag_err
    ram_busy = 1'b1;
    vga_rd_req = 1'b1;  vga_rd_address = 25'h8000;
    cam_wr_req = 1'b1;  cam_wr_address = 25'h8100;
    hdr_rd_req = 1'b1;  hdr_rd_address = 25'h8200;
    tick();
    vga_rd_req = 1'b0;  cam_wr_req = 1'b0;  hdr_rd_req = 1'b0;
    saw = 1'b0;
    repeat (20) begin
      tick();
      if (ram_req) saw = 1'b1;
    end
    check("t6_stall_noreq", saw, 1'b0);
    check("t6_slots_full", {cam_busy, vga_busy, hdr_busy}, 3'b111);
    ram_busy = 1'b0;
    wait_req(4, seen);
    check("t6_grant_after_busy", {seen, ram_address}, {1'b1, 25'h8000});
    #2;
    rst_133M = 1'b1;
    #1;
    check("t6_async_rst_req", {ram_req, ram_we}, 2'b00);
    check("t6_async_rst_busy", {cam_busy, vga_busy, hdr_busy}, 3'b000);
    check("t6_async_rst_addr", ram_address, 25'h0);
    tick();
    rst_133M = 1'b0;
    saw = 1'b0;
    repeat (5) begin
      tick();
      if (ram_req) saw = 1'b1;
    end
    check("t6_slots_dropped", saw, 1'b0);
    ram_rd_valid = 1'b1;
    ram_rd_data = {16{8'hEE}};
    tick();
    ram_rd_valid = 1'b0;
    check("t6_stray_no_valid", {vga_rd_valid, hdr_rd_valid}, 2'b00);
    check("t6_tag_err", tag_err, 1'b1);
    tick();
    check("t6_tag_err_sticky", tag_err, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
